step_ramp_generator: RTL
========================

STEP_RAMP_GENERATOR -- requirements
Module: step_ramp_generator

Interface
REQ-001 SHALL have parameter PULSE_W, default 4: step_out high time in clocks.
REQ-002 SHALL have port csi_MCLK_clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rsi_MRST_reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports avs_ctrl_address in 3, avs_ctrl_writedata in 32, avs_ctrl_byteenable in 4, avs_ctrl_write in 1, avs_ctrl_read in 1: Avalon-MM slave inputs.
REQ-005 SHALL have ports avs_ctrl_readdata out 32 and avs_ctrl_waitrequest out 1: Avalon-MM slave outputs.
REQ-006 SHALL have port step_out, output, 1: step pulse to the downstream driver's step input.
REQ-007 SHALL have port dir_out, output, 1: direction to the driver's forward_back input (1 = forward).
REQ-008 SHALL have port busy, output, 1: a move is in progress.

Function
REQ-009 SHALL map registers: 0 CTRL (W: bit0 start, bit1 abort, bit2 dir); 1 STEPS; 2 PERIOD_START; 3 PERIOD_MIN; 4 ACCEL_DEC; 5 STATUS (R: bit0 busy, bit1 done); 6 POSITION (R, signed).
REQ-010 SHALL honour byteenable per byte on registers 1-4; CTRL SHALL act on byte 0 only.
REQ-011 SHALL hold avs_ctrl_waitrequest at 0 and return read data one clock after avs_ctrl_read; unmapped addresses SHALL read 0.
REQ-012 SHALL ignore writes to registers 1-4 and to CTRL.dir while busy.
REQ-013 SHALL implement states IDLE, ACCEL, CRUISE, DECEL, DONE.
REQ-014 On start in IDLE or DONE: latch dir to dir_out, clear done and steps_done, load period = PERIOD_START, then enter ACCEL; if STEPS = 0, enter DONE instead and emit no pulse.
REQ-015 SHALL clamp the effective PERIOD_START and PERIOD_MIN to at least 2*PULSE_W, and the effective PERIOD_START to at least the effective PERIOD_MIN.
REQ-016 SHALL decrement a period counter every clock; on reaching 0, it SHALL raise step_out for PULSE_W clocks, increment steps_done, adjust POSITION by +1 or -1 per dir_out (wrapping mod 2^32), and reload the counter.
REQ-017 The first step_out rising edge SHALL occur PERIOD_START clocks after the start write is accepted.
REQ-018 In ACCEL, after each step: period = max(period - ACCEL_DEC, PERIOD_MIN) and ramp_steps += 1; SHALL enter CRUISE when period = PERIOD_MIN.
REQ-019 SHALL enter DECEL from ACCEL or CRUISE when STEPS - steps_done <= ramp_steps; in DECEL, period = min(period + ACCEL_DEC, PERIOD_START) after each step.
REQ-020 SHALL enter DONE, set done and clear busy on the clock after the step that makes steps_done = STEPS.
REQ-021 On abort while busy: enter DONE next clock, force step_out low, and hold steps_done and POSITION; abort in IDLE or DONE SHALL be ignored.
REQ-022 If start and abort are written together, abort SHALL win.
REQ-023 Start while busy SHALL be ignored.
REQ-024 All arithmetic SHALL be 32-bit unsigned except POSITION; period subtraction SHALL saturate at 0 before the max() clamp.

Reset
REQ-025 While rsi_MRST_reset_n = 0 at a clock edge: state IDLE; step_out, busy, done, dir_out and readdata 0; POSITION, STEPS and ACCEL_DEC 0; PERIOD_START and PERIOD_MIN 1000.
REQ-026 Reset asserted mid-move SHALL drop step_out and busy on that same edge with no partial-pulse completion.

Structure
REQ-027 Register addresses, CTRL/STATUS bit positions, state encoding and the reset period constant SHALL live in shared package step_motor_pkg.
REQ-028 The Avalon register file MAY be a sub-module step_ramp_regs; the ramp FSM and pulse timer SHALL stay in the top module.

Verification
REQ-029 STEPS=10, PERIOD_START=PERIOD_MIN=20, dir=1, start -> 10 pulses, 20 clocks apart, each 4 clocks high; POSITION=10; done=1.
REQ-030 STEPS=20, PERIOD_START=100, PERIOD_MIN=40, ACCEL_DEC=20, start -> periods 100,80,60,40...40,60,80,100; sequence symmetric.
REQ-031 STEPS=3 with the REQ-030 ramp -> pulse periods 100,80,100; CRUISE never entered.
REQ-032 Abort written after pulse 5 of a 100-step move -> step_out low next clock, POSITION=5, done=1, busy=0.
REQ-033 STEPS=0, start -> done=1 on the next clock, no pulse; PERIOD_MIN=1 -> effective period 8.
REQ-034 dir=0, 7 steps from POSITION=0 -> POSITION reads 0xFFFFFFF9; write to STEPS while busy -> old value still read back.

Source files
------------

// File: rtl/step_motor_pkg.sv
// Shared definitions for the step/ramp motion generator.
//   - Avalon register map (word addresses)
//   - CTRL and STATUS bit positions
//   - Ramp FSM state encoding
//   - Reset value for PERIOD_START / PERIOD_MIN
//   - Small arithmetic/byte-enable helpers
package step_motor_pkg;

  localparam logic [2:0] ADDR_CTRL         = 3'd0;
  localparam logic [2:0] ADDR_STEPS        = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_START = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_MIN   = 3'd3;
  localparam logic [2:0] ADDR_ACCEL_DEC    = 3'd4;
  localparam logic [2:0] ADDR_STATUS       = 3'd5;
  localparam logic [2:0] ADDR_POSITION     = 3'd6;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_DIR_BIT    = 2;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  localparam logic [31:0] RESET_PERIOD = 32'd1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL,
    ST_DONE
  } ramp_state_t;

  // Replace only the bytes of old_v selected by be with bytes of new_v.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] max_u32(input logic [31:0] a,
                                          input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_ramp_regs.sv
// Avalon-MM register file for step_ramp_generator.
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset_n : clock, synchronous active-low reset
//   avs_ctrl_*                     : Avalon-MM slave (fixed zero wait states,
//                                    read data registered one clock after read)
//   busy, done, position           : live status from the ramp FSM
//   steps .. accel_dec             : configuration registers (locked while busy)
//   cmd_start, cmd_abort, cmd_dir  : single-cycle decode of a CTRL byte-0 write
module step_ramp_regs
  import step_motor_pkg::*;
(
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [2:0]  avs_ctrl_address,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  input  logic        busy,
  input  logic        done,
  input  logic [31:0] position,
  output logic [31:0] steps,
  output logic [31:0] period_start,
  output logic [31:0] period_min,
  output logic [31:0] accel_dec,
  output logic        cmd_start,
  output logic        cmd_abort,
  output logic        cmd_dir
);

  logic        ctrl_wr;
  logic [31:0] rd_mux;

  assign avs_ctrl_waitrequest = 1'b0;

  // CTRL commands act only when byte lane 0 is enabled. The dir bit is only
  // consumed by the FSM alongside an accepted start, so it is inert while busy.
  assign ctrl_wr   = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL) && avs_ctrl_byteenable[0];
  assign cmd_start = ctrl_wr && avs_ctrl_writedata[CTRL_START_BIT];
  assign cmd_abort = ctrl_wr && avs_ctrl_writedata[CTRL_ABORT_BIT];
  assign cmd_dir   = avs_ctrl_writedata[CTRL_DIR_BIT];

  always_comb begin
    rd_mux = '0;
    case (avs_ctrl_address)
      ADDR_STEPS:        rd_mux = steps;
      ADDR_PERIOD_START: rd_mux = period_start;
      ADDR_PERIOD_MIN:   rd_mux = period_min;
      ADDR_ACCEL_DEC:    rd_mux = accel_dec;
      ADDR_STATUS: begin
        rd_mux[STATUS_BUSY_BIT] = busy;
        rd_mux[STATUS_DONE_BIT] = done;
      end
      ADDR_POSITION:     rd_mux = position;
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      steps             <= '0;
      period_start      <= RESET_PERIOD;
      period_min        <= RESET_PERIOD;
      accel_dec         <= '0;
      avs_ctrl_readdata <= '0;
    end else begin
      if (avs_ctrl_write && !busy) begin
        case (avs_ctrl_address)
          ADDR_STEPS:        steps        <= be_merge(steps, avs_ctrl_writedata, avs_ctrl_byteenable);
          ADDR_PERIOD_START: period_start <= be_merge(period_start, avs_ctrl_writedata, avs_ctrl_byteenable);
          ADDR_PERIOD_MIN:   period_min   <= be_merge(period_min, avs_ctrl_writedata, avs_ctrl_byteenable);
          ADDR_ACCEL_DEC:    accel_dec    <= be_merge(accel_dec, avs_ctrl_writedata, avs_ctrl_byteenable);
          default: ;
        endcase
      end
      avs_ctrl_readdata <= avs_ctrl_read ? rd_mux : '0;
    end
  end

endmodule

// File: rtl/step_ramp_generator.sv
// Trapezoidal step/direction generator with Avalon-MM control.
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset_n : clock, synchronous active-low reset
//   avs_ctrl_*                     : Avalon-MM slave to the register file
//   step_out                       : step pulse, PULSE_W clocks high
//   dir_out                        : direction latched at start (1 = forward)
//   busy                           : move in progress (ACCEL/CRUISE/DECEL)
// Parameter:
//   PULSE_W                        : step_out high time in clocks
module step_ramp_generator
  import step_motor_pkg::*;
#(
  parameter int PULSE_W = 4
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [2:0]  avs_ctrl_address,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy
);

  localparam logic [31:0] MIN_PERIOD = 32'(2 * PULSE_W);
  localparam logic [31:0] PULSE_LAST = 32'(PULSE_W - 1);

  logic [31:0] steps, period_start, period_min, accel_dec;
  logic        cmd_start, cmd_abort, cmd_dir;

  ramp_state_t state_q, state_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ramp_q, ramp_d;
  logic [31:0] sd_q, sd_d;
  logic [31:0] pos_q, pos_d;
  logic [31:0] pw_q, pw_d;
  logic        step_q, step_d;
  logic        done_q, done_d;
  logic        dir_q, dir_d;

  logic [31:0] pmin_eff, pstart_eff;
  logic [31:0] sd_inc, steps_left;
  logic [31:0] per_sub, per_accel, per_decel;
  logic [32:0] per_sum;

  step_ramp_regs u_regs (
    .csi_MCLK_clk         (csi_MCLK_clk),
    .rsi_MRST_reset_n     (rsi_MRST_reset_n),
    .avs_ctrl_address     (avs_ctrl_address),
    .avs_ctrl_writedata   (avs_ctrl_writedata),
    .avs_ctrl_byteenable  (avs_ctrl_byteenable),
    .avs_ctrl_write       (avs_ctrl_write),
    .avs_ctrl_read        (avs_ctrl_read),
    .avs_ctrl_readdata    (avs_ctrl_readdata),
    .avs_ctrl_waitrequest (avs_ctrl_waitrequest),
    .busy                 (busy),
    .done                 (done_q),
    .position             (pos_q),
    .steps                (steps),
    .period_start         (period_start),
    .period_min           (period_min),
    .accel_dec            (accel_dec),
    .cmd_start            (cmd_start),
    .cmd_abort            (cmd_abort),
    .cmd_dir              (cmd_dir)
  );

  assign busy     = (state_q == ST_ACCEL) || (state_q == ST_CRUISE) || (state_q == ST_DECEL);
  assign step_out = step_q;
  assign dir_out  = dir_q;

  // Periods never go below two pulse widths so pulses cannot overlap.
  assign pmin_eff   = max_u32(period_min, MIN_PERIOD);
  assign pstart_eff = max_u32(max_u32(period_start, MIN_PERIOD), pmin_eff);

  assign sd_inc     = sd_q + 32'd1;
  assign steps_left = steps - sd_inc;

  assign per_sub   = (period_q > accel_dec) ? (period_q - accel_dec) : '0;
  assign per_accel = (per_sub < pmin_eff) ? pmin_eff : per_sub;
  assign per_sum   = {1'b0, period_q} + {1'b0, accel_dec};
  assign per_decel = (per_sum > {1'b0, pstart_eff}) ? pstart_eff : per_sum[31:0];

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      ramp_q   <= '0;
      sd_q     <= '0;
      pos_q    <= '0;
      pw_q     <= '0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      ramp_q   <= ramp_d;
      sd_q     <= sd_d;
      pos_q    <= pos_d;
      pw_q     <= pw_d;
      step_q   <= step_d;
      done_q   <= done_d;
      dir_q    <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    ramp_d   = ramp_q;
    sd_d     = sd_q;
    pos_d    = pos_q;
    pw_d     = pw_q;
    step_d   = step_q;
    done_d   = done_q;
    dir_d    = dir_q;

    // Pulse timer runs in every state so the last pulse of a move keeps its
    // full width after the FSM has already moved to DONE.
    if (step_q) begin
      if (pw_q == '0) step_d = 1'b0;
      else            pw_d   = pw_q - 32'd1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_start && !cmd_abort) begin
          dir_d    = cmd_dir;
          done_d   = 1'b0;
          sd_d     = '0;
          ramp_d   = '0;
          period_d = pstart_eff;
          // Loaded with the full period: the step fires on the clock the
          // counter would reach 0, i.e. PERIOD_START clocks after the write.
          cnt_d    = pstart_eff;
          if (steps == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ACCEL;
          end
        end
      end
      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        if (cmd_abort) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          step_d  = 1'b0;
          pw_d    = '0;
        end else if (sd_q == steps) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (cnt_q <= 32'd1) begin
          step_d = 1'b1;
          pw_d   = PULSE_LAST;
          sd_d   = sd_inc;
          pos_d  = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
          // Deceleration is checked against the ramp length built so far
          // (before this step's increment) so short moves mirror their ramp.
          if ((state_q != ST_DECEL) && (steps_left <= ramp_q)) begin
            state_d  = ST_DECEL;
            period_d = per_decel;
          end else if (state_q == ST_ACCEL) begin
            period_d = per_accel;
            ramp_d   = ramp_q + 32'd1;
            if (per_accel == pmin_eff) state_d = ST_CRUISE;
          end else if (state_q == ST_DECEL) begin
            period_d = per_decel;
          end
          cnt_d = period_d;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
